// File: rtl/vdma_baseaddr_ctrl_pkg.sv
// Shared types and helpers for the VDMA triple-buffer base-address controller.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package vdma_addr_pkg;

  // Frame-slot spans for the two VDMA transfer modes (1080p).
  localparam int unsigned FRAME_STEP_LINE = 2211840;  // 256*8*1080
  localparam int unsigned FRAME_STEP_ONCE = 1555200;

  // Index of one of the three DDR frame slots of a channel.
  typedef logic [1:0] slot_t;

  // Reset permutation: writer, latest, reader.
  localparam slot_t SLOT_W_RST = 2'd0;
  localparam slot_t SLOT_L_RST = 2'd1;
  localparam slot_t SLOT_R_RST = 2'd2;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vdma_tribuf_slot.sv
// One channel's triple-buffer rotation: slot indices, flags, drop/repeat counters.
// Latency: indices and counters update on the edge that samples a frame-start pulse.
// Backpressure: none; every pulse is consumed in the cycle it arrives.
//
// Ports: axi_aclk/axi_resetn clock and async active-low reset; ch_enable forces the
// reset state synchronously while low; wr/rd_frame_start are single-cycle pulses;
// w/r are the writer/reader slot indices; rd_valid, drop_cnt, rep_cnt are status.
module vdma_tribuf_slot
  import vdma_addr_pkg::*;
(
  input  logic        axi_aclk,
  input  logic        axi_resetn,
  input  logic        ch_enable,
  input  logic        wr_frame_start,
  input  logic        rd_frame_start,
  output slot_t       w,
  output slot_t       r,
  output logic        rd_valid,
  output logic [15:0] drop_cnt,
  output logic [15:0] rep_cnt
);

  slot_t       l;
  logic        l_new;
  logic        wr_started;

  slot_t       w_nx, l_nx, r_nx;
  logic        l_new_nx, wr_started_nx, rd_valid_nx;
  logic [15:0] drop_nx, rep_nx;

  // The write rule is evaluated first and the read rule sees its result, so a
  // simultaneous read picks up the frame that just completed.
  always_comb begin
    w_nx          = w;
    l_nx          = l;
    r_nx          = r;
    l_new_nx      = l_new;
    wr_started_nx = wr_started;
    rd_valid_nx   = rd_valid;
    drop_nx       = drop_cnt;
    rep_nx        = rep_cnt;

    if (wr_frame_start) begin
      if (!wr_started) begin
        // First pulse only marks that a frame is being written; nothing complete yet.
        wr_started_nx = 1'b1;
      end else begin
        w_nx     = l;
        l_nx     = w;
        l_new_nx = 1'b1;
        // An unread latest frame is being recycled for writing.
        if (l_new) drop_nx = sat_inc16(drop_cnt);
      end
    end

    if (rd_frame_start) begin
      if (l_new_nx) begin
        r_nx        = l_nx;
        l_nx        = r;
        l_new_nx    = 1'b0;
        rd_valid_nx = 1'b1;
      end else if (rd_valid) begin
        rep_nx = sat_inc16(rep_cnt);
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      w          <= SLOT_W_RST;
      l          <= SLOT_L_RST;
      r          <= SLOT_R_RST;
      l_new      <= 1'b0;
      wr_started <= 1'b0;
      rd_valid   <= 1'b0;
      drop_cnt   <= '0;
      rep_cnt    <= '0;
    end else if (!ch_enable) begin
      w          <= SLOT_W_RST;
      l          <= SLOT_L_RST;
      r          <= SLOT_R_RST;
      l_new      <= 1'b0;
      wr_started <= 1'b0;
      rd_valid   <= 1'b0;
      drop_cnt   <= '0;
      rep_cnt    <= '0;
    end else begin
      w          <= w_nx;
      l          <= l_nx;
      r          <= r_nx;
      l_new      <= l_new_nx;
      wr_started <= wr_started_nx;
      rd_valid   <= rd_valid_nx;
      drop_cnt   <= drop_nx;
      rep_cnt    <= rep_nx;
    end
  end

endmodule

// File: rtl/vdma_baseaddr_ctrl.sv
// Per-channel triple-buffer DDR base-address generator feeding the multi-port VDMA core.
// Latency: 2 edges from frame-start pulse to new base address (index, then address register).
// Backpressure: none; pulses on consecutive cycles are all processed.
//
// Ports: axi_aclk/axi_resetn clock and async active-low reset; ch_enable,
// wr_frame_start, rd_frame_start per-channel controls; wr_baseaddr/rd_baseaddr
// per-channel slot addresses; rd_valid, drop_cnt, rep_cnt per-channel status.
module vdma_baseaddr_ctrl
  import vdma_addr_pkg::*;
#(
  parameter int                ASIZE      = 29,
  parameter int                CH_NUM     = 8,
  parameter longint unsigned   BASE_ADDR  = 0,
  parameter longint unsigned   FRAME_STEP = FRAME_STEP_LINE,
  parameter longint unsigned   CH_STEP    = 3 * FRAME_STEP
) (
  input  logic              axi_aclk,
  input  logic              axi_resetn,
  input  logic [CH_NUM-1:0] ch_enable,
  input  logic [CH_NUM-1:0] wr_frame_start,
  input  logic [CH_NUM-1:0] rd_frame_start,
  output logic [ASIZE-1:0]  wr_baseaddr [CH_NUM],
  output logic [ASIZE-1:0]  rd_baseaddr [CH_NUM],
  output logic [CH_NUM-1:0] rd_valid,
  output logic [15:0]       drop_cnt    [CH_NUM],
  output logic [15:0]       rep_cnt     [CH_NUM]
);

  // The whole frame-buffer region must fit in the DDR address space.
  if (BASE_ADDR + 64'(CH_NUM) * CH_STEP > (64'd1 << ASIZE)) begin : g_range_err
    $error("vdma_baseaddr_ctrl: frame-buffer region exceeds 2**ASIZE");
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    localparam logic [63:0] CH_BASE = 64'(BASE_ADDR) + 64'(c) * 64'(CH_STEP);
    localparam logic [63:0] RD_RST  = CH_BASE + 64'(SLOT_R_RST) * 64'(FRAME_STEP);
    localparam logic [63:0] WR_RST  = CH_BASE + 64'(SLOT_W_RST) * 64'(FRAME_STEP);

    slot_t       w, r;
    logic [63:0] wr_full, rd_full;

    vdma_tribuf_slot u_slot (
      .axi_aclk       (axi_aclk),
      .axi_resetn     (axi_resetn),
      .ch_enable      (ch_enable[c]),
      .wr_frame_start (wr_frame_start[c]),
      .rd_frame_start (rd_frame_start[c]),
      .w              (w),
      .r              (r),
      .rd_valid       (rd_valid[c]),
      .drop_cnt       (drop_cnt[c]),
      .rep_cnt        (rep_cnt[c])
    );

    // Full-width sum, truncated to the DDR address width on registration.
    assign wr_full = CH_BASE + 64'(w) * 64'(FRAME_STEP);
    assign rd_full = CH_BASE + 64'(r) * 64'(FRAME_STEP);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        wr_baseaddr[c] <= WR_RST[ASIZE-1:0];
        rd_baseaddr[c] <= RD_RST[ASIZE-1:0];
      end else begin
        wr_baseaddr[c] <= wr_full[ASIZE-1:0];
        rd_baseaddr[c] <= rd_full[ASIZE-1:0];
      end
    end
  end

endmodule
